packet_injector: RTL and testbench

Source-side network interface that turns a core's payload stream into wormhole packets for one router input port. It accepts a destination plus `FlitPerPacket-1` payload words per packet and emits one head flit, `FlitPerPacket-2` body flits and one tail flit. Its flit output drives one `data_in_bus`/`valid_in_bus`/`ready_in_bus` lane of the router, normally the local port. The flit output is registered, and the block sustains one flit per cycle under no backpressure.

---
 rtl/packet_injector.sv | 123 ++++++++++++
 tb/tb_packet_injector.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_injector.sv
// Source-side network interface: turns a core's destination + payload stream into
// head/body/tail wormhole flits through a single registered output slot.
module packet_injector #(
  parameter int N             = 100,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int FlitPerPacket = 6,
  parameter int ADDR_WIDTH    = $clog2(N),
  parameter int PAYLOAD_WIDTH = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    core_dest,
  input  logic [PAYLOAD_WIDTH-1:0] core_data,
  input  logic                     core_valid,
  output logic                     core_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [15:0]              packets_sent,
  output logic                     busy
);

  localparam int CNT_WIDTH = $clog2(FlitPerPacket);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(FlitPerPacket - 2);
  localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_BODY = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL = TYPE_WIDTH'(3);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [15:0]           packets_sent_q, packets_sent_d;

  logic                  slot_free;
  logic                  transfer;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] head_flit;
  logic [DATA_WIDTH-1:0] payload_flit;

  // The output slot may be reloaded when empty or when its flit leaves this cycle.
  assign slot_free  = !valid_q || ready_out;
  assign transfer   = valid_q && ready_out;
  assign core_ready = (state_q == PAYLOAD) && slot_free;
  assign handshake  = core_valid && core_ready;

  always_comb begin
    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]   = TYPE_HEAD;
    head_flit[ADDR_WIDTH-1:0]               = core_dest;
    head_flit[2*ADDR_WIDTH-1 -: ADDR_WIDTH] = ADDR_WIDTH'(INDEX);

    payload_flit = '0;
    payload_flit[PAYLOAD_WIDTH-1:0]          = core_data;
    payload_flit[DATA_WIDTH-1 -: TYPE_WIDTH] = (cnt_q == LAST_CNT) ? TYPE_TAIL : TYPE_BODY;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    valid_d        = valid_q;
    packets_sent_d = packets_sent_q;

    if (transfer && (data_q[DATA_WIDTH-1 -: TYPE_WIDTH] == TYPE_TAIL)) begin
      packets_sent_d = packets_sent_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (core_valid && slot_free) begin
          data_d  = head_flit;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = PAYLOAD;
        end else if (slot_free) begin
          valid_d = 1'b0;
        end
      end
      PAYLOAD: begin
        if (handshake) begin
          data_d  = payload_flit;
          valid_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (slot_free) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any partial packet; no tail is generated for it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      packets_sent_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      packets_sent_q <= packets_sent_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign packets_sent = packets_sent_q;
  assign busy         = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: two instances (6 and 2 flits per packet) share stimulus;
// a per-instance scoreboard queue tracks loaded flits until they are transferred.
module tb_packet_injector;

  localparam int AW = 7;
  localparam int PW = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] core_dest;
  logic [PW-1:0] core_data;
  logic          core_valid;
  logic          ready_out;

  logic          core_ready_a, valid_out_a, busy_a;
  logic [31:0]   data_out_a;
  logic [15:0]   packets_sent_a;
  logic          core_ready_b, valid_out_b, busy_b;
  logic [31:0]   data_out_b;
  logic [15:0]   packets_sent_b;

  packet_injector #(.FlitPerPacket(6)) dut_a (
    .clk(clk), .rst(rst), .core_dest(core_dest), .core_data(core_data),
    .core_valid(core_valid), .core_ready(core_ready_a), .data_out(data_out_a),
    .valid_out(valid_out_a), .ready_out(ready_out), .packets_sent(packets_sent_a),
    .busy(busy_a)
  );

  packet_injector #(.FlitPerPacket(2)) dut_b (
    .clk(clk), .rst(rst), .core_dest(core_dest), .core_data(core_data),
    .core_valid(core_valid), .core_ready(core_ready_b), .data_out(data_out_b),
    .valid_out(valid_out_b), .ready_out(ready_out), .packets_sent(packets_sent_b),
    .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] make_head(input logic [AW-1:0] dest);
    make_head = {2'b01, 16'd0, 7'd1, dest};
  endfunction

  // Reference model state, index 0 = dut_a, 1 = dut_b
  logic        m_valid [2];
  int          m_k     [2];
  logic [15:0] m_pkts  [2];
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  int          hs_b;
  logic        model_on = 1'b0;

  task automatic model_step(input int d, input logic [31:0] dout, input logic vout,
                            input logic cr, input logic bsy, input logic [15:0] ps);
    int          fpp;
    string       tag;
    logic        slot_free;
    logic        load;
    logic [31:0] front;
    logic [31:0] nf;
    int          qsize;
    fpp = (d == 0) ? 6 : 2;
    tag = (d == 0) ? "a" : "b";
    check($sformatf("%s_valid", tag), 32'(vout), 32'(m_valid[d]));
    check($sformatf("%s_busy", tag), 32'(bsy), 32'((m_k[d] != 0) || m_valid[d]));
    check($sformatf("%s_packets_sent", tag), 32'(ps), 32'(m_pkts[d]));
    slot_free = !m_valid[d] || ready_out;
    check($sformatf("%s_core_ready", tag), 32'(cr), 32'((m_k[d] != 0) && slot_free));

    if (m_valid[d]) begin
      qsize = (d == 0) ? sb_a.size() : sb_b.size();
      if (qsize == 0) begin
        check($sformatf("%s_sb_entry", tag), 32'(qsize), 32'd1);
      end else begin
        front = (d == 0) ? sb_a[0] : sb_b[0];
        check($sformatf("%s_data", tag), dout, front);
        if (ready_out) begin
          if (d == 0) void'(sb_a.pop_front());
          else        void'(sb_b.pop_front());
          if (front[31:30] == 2'b11) begin
            m_pkts[d] = m_pkts[d] + 16'd1;
            $display("dut_%s tail transferred, packets_sent -> %0d", tag, m_pkts[d]);
          end
        end
      end
    end

    load = 1'b0;
    nf   = 32'd0;
    if (core_valid && slot_free) begin
      load = 1'b1;
      if (m_k[d] == 0) begin
        nf     = make_head(core_dest);
        m_k[d] = 1;
      end else begin
        nf     = {(m_k[d] == fpp - 1) ? 2'b11 : 2'b10, core_data};
        m_k[d] = (m_k[d] == fpp - 1) ? 0 : m_k[d] + 1;
        if (d == 1) hs_b++;
      end
    end
    if (load) begin
      if (d == 0) sb_a.push_back(nf);
      else        sb_b.push_back(nf);
      m_valid[d] = 1'b1;
    end else if (slot_free) begin
      m_valid[d] = 1'b0;
    end

    if (!rst) begin
      m_valid[d] = 1'b0;
      m_k[d]     = 0;
      m_pkts[d]  = 16'd0;
      if (d == 0) sb_a.delete();
      else        sb_b.delete();
    end
  endtask

  task automatic run_models();
    if (model_on) begin
      model_step(0, data_out_a, valid_out_a, core_ready_a, busy_a, packets_sent_a);
      model_step(1, data_out_b, valid_out_b, core_ready_b, busy_b, packets_sent_b);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    run_models();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    core_valid = 1'b0;
    ready_out  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic          cv;
    logic [AW-1:0] dest;
    logic [PW-1:0] data;
    logic          rdy;
    logic          e_valid;
    logic          chk_data;
    logic [31:0]   e_data;
    logic          e_cr;
    logic [15:0]   e_pkts;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_ffff;
    int   stalls;

    // Head for dest 5 from INDEX 1: INDEX sits at bit 7, so 0x80 | 0x05.
    vecs[0] = '{1'b1, 7'd5, 30'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 7'd5, 30'd1, 1'b1, 1'b1, 1'b1, 32'h4000_0085, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 7'd5, 30'd2, 1'b1, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 7'd5, 30'd3, 1'b1, 1'b1, 1'b1, 32'h8000_0002, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 7'd5, 30'd4, 1'b1, 1'b1, 1'b1, 32'h8000_0003, 1'b1, 16'd0};
    vecs[5] = '{1'b1, 7'd5, 30'd5, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 16'd0};
    vecs[6] = '{1'b0, 7'd5, 30'd5, 1'b1, 1'b1, 1'b1, 32'hC000_0005, 1'b0, 16'd0};
    vecs[7] = '{1'b0, 7'd5, 30'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd1};

    rst        = 1'b0;
    core_valid = 1'b0;
    core_dest  = 7'd0;
    core_data  = 30'd0;
    ready_out  = 1'b1;
    for (int i = 0; i < 2; i++) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_k[d]     = 0;
      m_pkts[d]  = 16'd0;
    end
    hs_b     = 0;
    model_on = 1'b1;

    // Outputs while reset is held
    @(negedge clk);
    check("rst_data_out", data_out_a, 32'd0);
    check("rst_core_ready", 32'(core_ready_a), 32'd0);
    run_models();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Test 1: single packet, table-driven
    for (int i = 0; i < 8; i++) begin
      core_valid = vecs[i].cv;
      core_dest  = vecs[i].dest;
      core_data  = vecs[i].data;
      ready_out  = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("t1_valid[%0d]", i), 32'(valid_out_a), 32'(vecs[i].e_valid));
      if (vecs[i].chk_data)
        check($sformatf("t1_data[%0d]", i), data_out_a, vecs[i].e_data);
      check($sformatf("t1_core_ready[%0d]", i), 32'(core_ready_a), 32'(vecs[i].e_cr));
      check($sformatf("t1_packets[%0d]", i), 32'(packets_sent_a), 32'(vecs[i].e_pkts));
      $display("t1 vector %0d: valid=%0b data=%h core_ready=%0b", i, valid_out_a, data_out_a, core_ready_a);
      run_models();
      @(posedge clk);
      #1;
    end

    // Test 2: three back-to-back packets with no backpressure
    do_reset();
    ready_out = 1'b1;
    core_dest = 7'd9;
    for (int c = 0; c < 20; c++) begin
      core_valid = (c < 18);
      core_data  = 30'($urandom);
      @(negedge clk);
      if (c >= 1 && c <= 18) begin
        check($sformatf("t2_valid_a[%0d]", c), 32'(valid_out_a), 32'd1);
        check($sformatf("t2_type_a[%0d]", c), 32'(data_out_a[31:30]),
              ((c - 1) % 6 == 0) ? 32'd1 : (((c - 1) % 6 == 5) ? 32'd3 : 32'd2));
        check($sformatf("t2_type_b[%0d]", c), 32'(data_out_b[31:30]),
              ((c - 1) % 2 == 0) ? 32'd1 : 32'd3);
      end
      run_models();
      @(posedge clk);
      #1;
    end
    tick();
    check("t2_packets_a", 32'(packets_sent_a), 32'd3);
    check("t2_packets_b", 32'(packets_sent_b), 32'd9);

    // Test 3: random backpressure, random core_valid and destinations
    do_reset();
    hs_b   = 0;
    stalls = 0;
    for (int c = 0; c < 400; c++) begin
      ready_out  = 1'($urandom_range(0, 1));
      core_valid = ($urandom_range(0, 3) != 0);
      core_dest  = 7'($urandom_range(0, 99));
      core_data  = 30'($urandom);
      if (valid_out_a && !ready_out) stalls++;
      tick();
    end
    core_valid = 1'b0;
    ready_out  = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    $display("t3 done: %0d stalled cycles on dut_a", stalls);
    check("t3_sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("t3_sb_b_drained", 32'(sb_b.size()), 32'd0);
    check("t4_payloads_per_packet_b", 32'(packets_sent_b), 32'(hs_b));

    // Test 5: reset while the third flit of a packet is on the output
    do_reset();
    ready_out  = 1'b1;
    core_dest  = 7'd1;
    for (int c = 0; c < 10; c++) begin
      core_valid = 1'b1;
      core_data  = 30'(c + 100);
      rst        = (c == 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 9) begin
        check("t5_third_flit_type", 32'(data_out_a[31:30]), 32'd2);
        check("t5_packets_before", 32'(packets_sent_a), 32'd1);
      end
      run_models();
      @(posedge clk);
      #1;
    end
    rst        = 1'b1;
    core_valid = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(valid_out_a), 32'd0);
    check("t5_busy_after_rst", 32'(busy_a), 32'd0);
    check("t5_packets_after_rst", 32'(packets_sent_a), 32'd0);
    run_models();
    @(posedge clk);
    #1;
    core_valid = 1'b1;
    core_dest  = 7'd3;
    tick();
    @(negedge clk);
    check("t5_fresh_head_valid", 32'(valid_out_a), 32'd1);
    check("t5_fresh_head", data_out_a, 32'h4000_0083);
    run_models();
    @(posedge clk);
    #1;

    // Test 6: packets_sent wrap on dut_b via a preloaded count
    do_reset();
    @(negedge clk);
    force dut_b.packets_sent_q = 16'hFFFE;
    @(negedge clk);
    release dut_b.packets_sent_q;
    m_pkts[1] = 16'hFFFE;
    @(posedge clk);
    #1;
    seen_ffff = 1'b0;
    for (int c = 0; c < 7; c++) begin
      core_valid = (c < 4);
      core_data  = 30'(c);
      if (packets_sent_b == 16'hFFFF) seen_ffff = 1'b1;
      tick();
    end
    check("t6_reached_ffff", 32'(seen_ffff), 32'd1);
    check("t6_wrapped_to_zero", 32'(packets_sent_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
